// File: rtl/linked_list_fifo_rr_drain_pkg.sv
// Shared constants and helpers for the linked-list FIFO drain stage.
package linked_list_fifo_rr_drain_pkg;

    localparam int BUF_DEPTH = 3;

    // Bits needed to represent x (minimum 1), matching the FIFO's LOG2_* sizing.
    function automatic int log2(input int x);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= x) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/linked_list_fifo_rr_drain_rr_arbiter.sv
// Round-robin pick: first requesting index scanning upward from last+1.
// Purely combinational, zero latency; no flow control of its own.
module rr_arbiter
    import linked_list_fifo_rr_drain_pkg::*;
#(
    parameter  int N  = 8,
    localparam int LW = log2(N - 1)
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic          grant_valid_o,
    output logic [LW-1:0] grant_idx_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last_i) + i) % N;
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/linked_list_fifo_rr_drain.sv
// Round-robin drain of linked_list_fifo queues onto a tagged valid/ready stream.
// Latency: two edges pop->out_valid; 1 word/cycle sustained with out_ready_i high.
// Back-pressure: credit of 3 (buffer + in-flight); error check under LINKED_LIST_FIFO_DRAIN_ERROR_EN.
module linked_list_fifo_rr_drain
    import linked_list_fifo_rr_drain_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 32,
    parameter  int FIFOS      = 8,
    localparam int LOG2_FIFO  = log2(FIFOS - 1),
    localparam int LOG2_DEPTH = log2(DEPTH - 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [LOG2_FIFO-1:0] push_fifo_i,
    input  logic [FIFOS-1:0]     fifo_en_i,
    output logic                 pop_o,
    output logic [LOG2_FIFO-1:0] pop_fifo_o,
    input  logic [WIDTH-1:0]     q_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic [LOG2_FIFO-1:0] out_fifo_o,
    output logic                 error_o
);

    logic [LOG2_DEPTH:0]   occ_q [FIFOS];
    logic [LOG2_FIFO-1:0]  last_q;
    logic                  infl_q;
    logic [LOG2_FIFO-1:0]  infl_fifo_q;
    logic [WIDTH-1:0]      buf_dat_q [BUF_DEPTH];
    logic [LOG2_FIFO-1:0]  buf_tag_q [BUF_DEPTH];
    logic [1:0]            wr_ptr_q, rd_ptr_q, buf_cnt_q, buf_cnt_d;

    logic [FIFOS-1:0]      elig;
    logic                  grant_vld;
    logic [LOG2_FIFO-1:0]  grant_idx;
    logic                  credit_ok, buf_wr, buf_rd;

    always_comb begin
        elig = '0;
        for (int f = 0; f < FIFOS; f++) begin
            elig[f] = (occ_q[f] != '0) && fifo_en_i[f];
        end
    end

    rr_arbiter #(.N(FIFOS)) u_arb (
        .req_i         (elig),
        .last_i        (last_q),
        .grant_valid_o (grant_vld),
        .grant_idx_o   (grant_idx)
    );

    assign credit_ok  = ({1'b0, buf_cnt_q} + {2'b00, infl_q}) < 3'(BUF_DEPTH);
    assign pop_o      = grant_vld && credit_ok;
    assign pop_fifo_o = pop_o ? grant_idx : '0;

    assign out_valid_o = (buf_cnt_q != 2'd0);
    assign out_data_o  = buf_dat_q[rd_ptr_q];
    assign out_fifo_o  = buf_tag_q[rd_ptr_q];
    assign buf_wr      = infl_q;
    assign buf_rd      = out_valid_o && out_ready_i;

    always_comb begin
        buf_cnt_d = buf_cnt_q;
        if (buf_wr && !buf_rd) buf_cnt_d = buf_cnt_q + 2'd1;
        if (buf_rd && !buf_wr) buf_cnt_d = buf_cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int f = 0; f < FIFOS; f++) occ_q[f] <= '0;
            for (int b = 0; b < BUF_DEPTH; b++) begin
                buf_dat_q[b] <= '0;
                buf_tag_q[b] <= '0;
            end
            last_q      <= LOG2_FIFO'(FIFOS - 1);
            infl_q      <= 1'b0;
            infl_fifo_q <= '0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            buf_cnt_q   <= 2'd0;
        end else begin
            // A push and pop hitting the same queue cancel out.
            for (int f = 0; f < FIFOS; f++) begin
                if (push_i && push_fifo_i == LOG2_FIFO'(f) &&
                    !(pop_o && pop_fifo_o == LOG2_FIFO'(f)))
                    occ_q[f] <= occ_q[f] + 1'b1;
                else if (pop_o && pop_fifo_o == LOG2_FIFO'(f) &&
                         !(push_i && push_fifo_i == LOG2_FIFO'(f)))
                    occ_q[f] <= occ_q[f] - 1'b1;
            end
            if (pop_o) last_q <= grant_idx;
            infl_q      <= pop_o;
            infl_fifo_q <= pop_fifo_o;
            if (buf_wr) begin
                buf_dat_q[wr_ptr_q] <= q_i;
                buf_tag_q[wr_ptr_q] <= infl_fifo_q;
                wr_ptr_q            <= buf_ptr_inc(wr_ptr_q);
            end
            if (buf_rd) rd_ptr_q <= buf_ptr_inc(rd_ptr_q);
            buf_cnt_q <= buf_cnt_d;
        end
    end

`ifdef LINKED_LIST_FIFO_DRAIN_ERROR_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if ((push_i && occ_q[push_fifo_i] == (LOG2_DEPTH+1)'(DEPTH)) ||
                     (buf_wr && buf_cnt_q == 2'(BUF_DEPTH))) begin
            err_q <= 1'b1;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_linked_list_fifo_rr_drain.sv
// Bench for linked_list_fifo_rr_drain: FIFO model supplies q, per-queue scoreboard checks output.
module tb_linked_list_fifo_rr_drain;

`ifdef LINKED_LIST_FIFO_DRAIN_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       push_i;
    logic [2:0] push_fifo_i;
    logic [7:0] fifo_en_i;
    logic       pop_o;
    logic [2:0] pop_fifo_o;
    logic [7:0] q_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_data_o;
    logic [2:0] out_fifo_o;
    logic       error_o;

    always #5 clk_i = ~clk_i;

    linked_list_fifo_rr_drain dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_i),
        .push_fifo_i (push_fifo_i),
        .fifo_en_i   (fifo_en_i),
        .pop_o       (pop_o),
        .pop_fifo_o  (pop_fifo_o),
        .q_i         (q_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_fifo_o  (out_fifo_o),
        .error_o     (error_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] fifo_mem [8][$];
    logic [7:0] exp_q    [8][$];
    logic [2:0] log_f [$];
    logic [7:0] log_d [$];
    int  n_pop, n_out;
    bit  pend_v;
    logic [2:0] pend_f;
    bit  have_prev, prev_v, prev_r;
    logic [7:0] prev_d;
    logic [2:0] prev_f;
    int  mon_f;
    logic [7:0] mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_total();
        int s = 0;
        for (int i = 0; i < 8; i++) s += exp_q[i].size();
        return s;
    endfunction

    function automatic int mem_total();
        int s = 0;
        for (int i = 0; i < 8; i++) s += fifo_mem[i].size();
        return s;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 8; i++) begin
            fifo_mem[i].delete();
            exp_q[i].delete();
        end
        log_f.delete();
        log_d.delete();
        n_pop = 0;
        n_out = 0;
    endtask

    // Attached FIFO model: q is valid the cycle after a sampled pop.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (pend_v) begin
            if (fifo_mem[pend_f].size() != 0) q_i = fifo_mem[pend_f].pop_front();
            else q_i = 8'hEE;
            pend_v = 1'b0;
        end
    end

    // Output monitor: scoreboard per queue, hold-while-stalled, credit bound.
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            have_prev = 1'b0;
            pend_v    = 1'b0;
        end else begin
            if (have_prev && prev_v && !prev_r) begin
                chk("hold_valid", out_valid_o, 1);
                chk("hold_data", out_data_o, prev_d);
                chk("hold_fifo", out_fifo_o, prev_f);
            end
            if (pop_o) begin
                chk("credit", (n_pop - n_out) < 3, 1);
                n_pop++;
            end
            pend_v = pop_o;
            pend_f = pop_fifo_o;
            if (out_valid_o && out_ready_i) begin
                mon_f = int'(out_fifo_o);
                chk("sb_nonempty", exp_q[mon_f].size() != 0, 1);
                if (exp_q[mon_f].size() != 0) begin
                    mon_d = exp_q[mon_f].pop_front();
                    chk("sb_data", out_data_o, mon_d);
                end
                log_f.push_back(out_fifo_o);
                log_d.push_back(out_data_o);
                n_out++;
            end
            prev_v    = out_valid_o;
            prev_r    = out_ready_i;
            prev_d    = out_data_o;
            prev_f    = out_fifo_o;
            have_prev = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        push_i = 1'b0;
        repeat (2) tick();
        clear_models();
        rst_i = 1'b0;
    endtask

    task automatic push_word(input int f, input logic [7:0] d, input bit track);
        push_i      = 1'b1;
        push_fifo_i = f[2:0];
        if (track) begin
            fifo_mem[f].push_back(d);
            exp_q[f].push_back(d);
        end
        tick();
        push_i = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (log_f.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, log_f.size(), n);
    endtask

    task automatic preload32(output logic [7:0] first_d);
        fifo_en_i = 8'h00;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (i == 0) first_d = d;
            push_word(i % 8, d, 1'b1);
        end
    endtask

    typedef struct {
        int         f;
        logic [7:0] d;
        int         lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int edges;
        logic [7:0] first_d;

        tbl[0] = '{0, 8'h05, 3};
        tbl[1] = '{3, 8'hA5, 3};
        tbl[2] = '{7, 8'hFF, 3};
        tbl[3] = '{4, 8'h00, 3};
        tbl[4] = '{6, 8'h81, 3};
        tbl[5] = '{1, 8'h3C, 3};

        rst_i = 1'b1; push_i = 1'b0; push_fifo_i = '0; fifo_en_i = 8'h00;
        q_i = '0; out_ready_i = 1'b0;
        pend_v = 1'b0; have_prev = 1'b0;
        clear_models();
        repeat (2) tick();
        chk("rst_pop", pop_o, 0);
        chk("rst_pop_fifo", pop_fifo_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_fifo", out_fifo_o, 0);
        chk("rst_error", error_o, 0);
        rst_i = 1'b0;
        tick();

        // Single-word latency table.
        fifo_en_i = 8'hFF;
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_i = 1'b1;
            push_fifo_i = tbl[k].f[2:0];
            fifo_mem[tbl[k].f].push_back(tbl[k].d);
            exp_q[tbl[k].f].push_back(tbl[k].d);
            tick();
            push_i = 1'b0;
            edges = 1;
            while (!out_valid_o && edges < 10) begin
                tick();
                edges++;
            end
            chk("tbl_latency", edges, tbl[k].lat);
            chk("tbl_fifo", out_fifo_o, tbl[k].f);
            chk("tbl_data", out_data_o, tbl[k].d);
            repeat (3) tick();
        end

        // Back-to-back words on queue 0 keep order.
        do_reset();
        fifo_en_i = 8'hFF; out_ready_i = 1'b1;
        push_word(0, 8'd5, 1'b1);
        push_word(0, 8'd6, 1'b1);
        wait_log(2, 20, "q0_pair_count");
        if (log_d.size() >= 2) begin
            chk("q0_first", log_d[0], 5);
            chk("q0_second", log_d[1], 6);
            chk("q0_tag", log_f[1], 0);
        end

        // Masked queues, then enable: order 1,2,5; last=5 makes 6 precede 0.
        do_reset();
        fifo_en_i = 8'h00; out_ready_i = 1'b1;
        push_word(1, 8'h11, 1'b1);
        push_word(2, 8'h22, 1'b1);
        push_word(5, 8'h55, 1'b1);
        repeat (3) tick();
        chk("masked_pop", pop_o, 0);
        chk("masked_valid", out_valid_o, 0);
        fifo_en_i = 8'hFF;
        wait_log(3, 20, "en_count");
        if (log_f.size() >= 3) begin
            chk("en_order0", log_f[0], 1);
            chk("en_order1", log_f[1], 2);
            chk("en_order2", log_f[2], 5);
        end
        fifo_en_i = 8'h00;
        push_word(0, 8'h00, 1'b1);
        push_word(6, 8'h66, 1'b1);
        fifo_en_i = 8'hFF;
        wait_log(5, 20, "last_count");
        if (log_f.size() >= 5) begin
            chk("last_order0", log_f[3], 6);
            chk("last_order1", log_f[4], 0);
        end

        // Preload 32 words, drain with no bubbles, tags cycling 0..7.
        do_reset();
        preload32(first_d);
        out_ready_i = 1'b1;
        fifo_en_i = 8'hFF;
        edges = 0;
        while (!out_valid_o && edges < 10) begin
            tick();
            edges++;
        end
        for (int k = 0; k < 32; k++) begin
            chk("stream_valid", out_valid_o, 1);
            chk("stream_rr", out_fifo_o, k % 8);
            tick();
        end
        repeat (2) tick();
        chk("stream_count", log_f.size(), 32);
        chk("stream_left", exp_total(), 0);

        // Same preload stalled: only 3 pops, then resume without loss.
        do_reset();
        preload32(first_d);
        out_ready_i = 1'b0;
        fifo_en_i = 8'hFF;
        repeat (10) tick();
        chk("stall_pops", n_pop, 3);
        chk("stall_pop_now", pop_o, 0);
        chk("stall_valid", out_valid_o, 1);
        chk("stall_fifo", out_fifo_o, 0);
        chk("stall_data", out_data_o, first_d);
        out_ready_i = 1'b1;
        wait_log(32, 100, "resume_count");
        chk("resume_left", exp_total(), 0);

        // Reset with two words buffered discards them.
        do_reset();
        fifo_en_i = 8'hFF; out_ready_i = 1'b0;
        push_word(2, 8'h12, 1'b1);
        push_word(2, 8'h34, 1'b1);
        repeat (5) tick();
        chk("prerst_valid", out_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("midrst_pop", pop_o, 0);
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_data", out_data_o, 0);
        chk("midrst_fifo", out_fifo_o, 0);
        chk("midrst_error", error_o, 0);
        tick();
        clear_models();
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        push_word(3, 8'h77, 1'b1);
        wait_log(1, 10, "postrst_count");
        if (log_f.size() >= 1) begin
            chk("postrst_fifo", log_f[0], 3);
            chk("postrst_data", log_d[0], 8'h77);
        end

        // Randomized traffic against the scoreboard.
        do_reset();
        fifo_en_i = 8'hFF;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 1) == 1 && mem_total() < 30) begin
                int f;
                logic [7:0] d;
                f = $urandom_range(0, 7);
                d = 8'($urandom);
                push_i = 1'b1;
                push_fifo_i = f[2:0];
                fifo_mem[f].push_back(d);
                exp_q[f].push_back(d);
            end else begin
                push_i = 1'b0;
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            if (c % 50 == 0) fifo_en_i = 8'($urandom);
            tick();
        end
        push_i = 1'b0;
        fifo_en_i = 8'hFF;
        out_ready_i = 1'b1;
        edges = 0;
        while ((exp_total() != 0 || out_valid_o) && edges < 300) begin
            tick();
            edges++;
        end
        chk("rand_drained", exp_total(), 0);
        chk("rand_error", error_o, 0);

        // Occupancy overflow: 33 snooped pushes to a masked queue.
        do_reset();
        fifo_en_i = 8'h00;
        for (int i = 0; i < 33; i++) begin
            push_word(4, 8'(i), 1'b0);
            if (i == 31) chk("err_at_32", error_o, 0);
        end
        chk("err_at_33", error_o, ERR_EN);
        repeat (5) tick();
        chk("err_sticky", error_o, ERR_EN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
